// File: rtl/navic_pilot_seq_ctrl.sv
// NavIC L1 pilot code generator sequencer.
// Takes PRN/run commands over a valid/ready port and drives the generator's
// PRN select, IC reload and chip enable. Runs are counted in primary-code
// epochs and always end on an epoch boundary. A one-deep shadow register
// holds the next command, so a PRN change lands on the next epoch without
// any timing constraints on the host.
module navic_pilot_seq_ctrl #(
    parameter int PRN_W       = 6,
    parameter int CNT_W       = 16,
    parameter int LOAD_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [PRN_W-1:0] cmd_prn_i,
    input  logic [CNT_W-1:0] cmd_epochs_i,
    input  logic             cmd_sync_i,
    input  logic             sync_in_i,
    input  logic             abort_i,
    input  logic             gen_epoch_i,
    output logic [PRN_W-1:0] gen_prn_o,
    output logic             gen_load_o,
    output logic             gen_ena_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             cmd_err_o,
    output logic [CNT_W-1:0] epoch_count_o
);

    // The load counter only ever holds 0..LOAD_CYCLES-1.
    localparam int LC_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [LC_W-1:0] LOAD_INIT = LC_W'(LOAD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ARM  = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t            state_q;
    logic [PRN_W-1:0]  gen_prn_q;
    logic [CNT_W-1:0]  target_q;
    logic              sync_q;
    logic              gen_load_q;
    logic              gen_ena_q;
    logic              done_q;
    logic              cmd_err_q;
    logic [CNT_W-1:0]  epoch_count_q;
    logic [LC_W-1:0]   load_cnt_q;

    logic              shadow_valid_q;
    logic [PRN_W-1:0]  shadow_prn_q;
    logic [CNT_W-1:0]  shadow_target_q;
    logic              shadow_sync_q;

    logic              accept;
    logic              accept_ok;
    logic              accept_bad;
    logic [CNT_W-1:0]  epoch_count_d;
    logic              target_hit;
    logic              shadow_load;
    logic              start_load;
    logic [PRN_W-1:0]  ld_prn_d;
    logic [CNT_W-1:0]  ld_target_d;
    logic              ld_sync_d;

    // Ready whenever idle, or while busy with room in the shadow; abort blocks it.
    assign cmd_ready_o = !abort_i && ((state_q == ST_IDLE) || !shadow_valid_q);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign accept_ok   = accept && (cmd_prn_i != '0);
    assign accept_bad  = accept && (cmd_prn_i == '0);

    assign epoch_count_d = epoch_count_q + CNT_W'(1);
    assign target_hit    = (target_q != '0) && (epoch_count_d == target_q);

    // Decide whether a LOAD starts this cycle and which command it loads.
    // The epoch decision looks only at the shadow as it stood before any
    // accept in the same cycle, so a fresh command is never consumed early.
    always_comb begin
        shadow_load = 1'b0;
        start_load  = 1'b0;
        ld_prn_d    = shadow_prn_q;
        ld_target_d = shadow_target_q;
        ld_sync_d   = shadow_sync_q;
        if (state_q == ST_IDLE) begin
            if (shadow_valid_q) begin
                shadow_load = 1'b1;
                start_load  = 1'b1;
            end else if (accept_ok) begin
                start_load  = 1'b1;
                ld_prn_d    = cmd_prn_i;
                ld_target_d = cmd_epochs_i;
                ld_sync_d   = cmd_sync_i;
            end
        end else if ((state_q == ST_RUN) && gen_epoch_i && shadow_valid_q &&
                     ((target_q == '0) || target_hit)) begin
            shadow_load = 1'b1;
            start_load  = 1'b1;
        end
    end

    // Sequencer FSM with registered generator controls and status pulses.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= ST_IDLE;
            gen_prn_q       <= PRN_W'(1);
            target_q        <= '0;
            sync_q          <= 1'b0;
            gen_load_q      <= 1'b0;
            gen_ena_q       <= 1'b0;
            done_q          <= 1'b0;
            cmd_err_q       <= 1'b0;
            epoch_count_q   <= '0;
            load_cnt_q      <= '0;
            shadow_valid_q  <= 1'b0;
            shadow_prn_q    <= '0;
            shadow_target_q <= '0;
            shadow_sync_q   <= 1'b0;
        end else if (abort_i) begin
            // Stop the generator at once; the count of the cut run is kept.
            state_q        <= ST_IDLE;
            gen_load_q     <= 1'b0;
            gen_ena_q      <= 1'b0;
            done_q         <= 1'b0;
            cmd_err_q      <= 1'b0;
            shadow_valid_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cmd_err_q <= accept_bad;

            // A good command goes to the shadow unless it starts a run directly.
            if (accept_ok && !((state_q == ST_IDLE) && !shadow_valid_q)) begin
                shadow_valid_q  <= 1'b1;
                shadow_prn_q    <= cmd_prn_i;
                shadow_target_q <= cmd_epochs_i;
                shadow_sync_q   <= cmd_sync_i;
            end else if (shadow_load) begin
                shadow_valid_q <= 1'b0;
            end

            if (start_load) begin
                state_q       <= ST_LOAD;
                gen_prn_q     <= ld_prn_d;
                target_q      <= ld_target_d;
                sync_q        <= ld_sync_d;
                gen_load_q    <= 1'b1;
                gen_ena_q     <= 1'b0;
                load_cnt_q    <= LOAD_INIT;
                epoch_count_q <= '0;
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        if (load_cnt_q == '0) begin
                            gen_load_q <= 1'b0;
                            if (sync_q) begin
                                state_q <= ST_ARM;
                            end else begin
                                state_q   <= ST_RUN;
                                gen_ena_q <= 1'b1;
                            end
                        end else begin
                            load_cnt_q <= load_cnt_q - LC_W'(1);
                        end
                    end
                    ST_ARM: begin
                        if (sync_in_i) begin
                            state_q   <= ST_RUN;
                            gen_ena_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (gen_epoch_i) begin
                            epoch_count_q <= epoch_count_d;
                            if (target_hit) begin
                                state_q   <= ST_IDLE;
                                gen_ena_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign gen_prn_o     = gen_prn_q;
    assign gen_load_o    = gen_load_q;
    assign gen_ena_o     = gen_ena_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign cmd_err_o     = cmd_err_q;
    assign epoch_count_o = epoch_count_q;

endmodule

// File: tb/tb_navic_pilot_seq_ctrl.sv
// Testbench for navic_pilot_seq_ctrl: a table of single-cycle vectors for the
// basic run/error/abort behaviour, then hand-written multi-cycle sequences.
module tb_navic_pilot_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_prn;
    logic [15:0] cmd_epochs;
    logic        cmd_sync;
    logic        sync_in;
    logic        abort;
    logic        gen_epoch;
    logic [5:0]  gen_prn;
    logic        gen_load;
    logic        gen_ena;
    logic        busy;
    logic        done;
    logic        cmd_err;
    logic [15:0] epoch_count;

    int total = 0;
    int bad   = 0;

    navic_pilot_seq_ctrl #(
        .PRN_W(6), .CNT_W(16), .LOAD_CYCLES(2)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_prn_i(cmd_prn), .cmd_epochs_i(cmd_epochs), .cmd_sync_i(cmd_sync),
        .sync_in_i(sync_in), .abort_i(abort), .gen_epoch_i(gen_epoch),
        .gen_prn_o(gen_prn), .gen_load_o(gen_load), .gen_ena_o(gen_ena),
        .busy_o(busy), .done_o(done), .cmd_err_o(cmd_err),
        .epoch_count_o(epoch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [5:0]  prn;
        logic [15:0] ep;
        logic        sy;
        logic        si;
        logic        ab;
        logic        ge;
        logic        rdy;
        logic [5:0]  xprn;
        logic        xld;
        logic        xena;
        logic        xbusy;
        logic        xdone;
        logic        xerr;
        logic [15:0] xcnt;
    } vec_t;

    localparam int NVEC = 12;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic v, input logic [5:0] prn, input logic [15:0] ep,
                                input logic sy, input logic si, input logic ab, input logic ge,
                                input logic rdy, input logic [5:0] xprn, input logic xld,
                                input logic xena, input logic xbusy, input logic xdone,
                                input logic xerr, input logic [15:0] xcnt);
        vec_t r;
        r.v = v; r.prn = prn; r.ep = ep; r.sy = sy; r.si = si; r.ab = ab; r.ge = ge;
        r.rdy = rdy; r.xprn = xprn; r.xld = xld; r.xena = xena; r.xbusy = xbusy;
        r.xdone = xdone; r.xerr = xerr; r.xcnt = xcnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string t, input logic [5:0] p, input logic ld, input logic en,
                           input logic bz, input logic dn, input logic er, input logic [15:0] c);
        chk({t, ".gen_prn"}, 32'(gen_prn), 32'(p));
        chk({t, ".gen_load"}, 32'(gen_load), 32'(ld));
        chk({t, ".gen_ena"}, 32'(gen_ena), 32'(en));
        chk({t, ".busy"}, 32'(busy), 32'(bz));
        chk({t, ".done"}, 32'(done), 32'(dn));
        chk({t, ".cmd_err"}, 32'(cmd_err), 32'(er));
        chk({t, ".epoch_count"}, 32'(epoch_count), 32'(c));
    endtask

    // Drive one cycle of inputs, report cmd_ready before the edge, then move
    // to just after the active edge so registered outputs can be sampled.
    task automatic step(input logic v, input logic [5:0] prn, input logic [15:0] ep,
                        input logic sy, input logic si, input logic ab, input logic ge,
                        output logic rdy);
        cmd_valid  = v;
        cmd_prn    = prn;
        cmd_epochs = ep;
        cmd_sync   = sy;
        sync_in    = si;
        abort      = ab;
        gen_epoch  = ge;
        #1;
        rdy = cmd_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic r;
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, r);
    endtask

    logic r;

    initial begin
        // Vectors start in IDLE right after reset: gen_prn=1, count 0.
        tbl[0]  = mk(1, 3, 2, 0, 0, 0, 0,  1, 3, 1, 0, 1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 3, 1, 0, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 3, 0, 1, 1, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 1,  1, 3, 0, 1, 1, 0, 0, 1);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 3, 0, 1, 1, 0, 0, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1,  1, 3, 0, 0, 0, 1, 0, 2);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 3, 0, 0, 0, 0, 0, 2);
        tbl[7]  = mk(1, 0, 5, 0, 0, 0, 0,  1, 3, 0, 0, 0, 0, 1, 2);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 3, 0, 0, 0, 0, 0, 2);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1,  1, 3, 0, 0, 0, 0, 0, 2);
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 0,  0, 3, 0, 0, 0, 0, 0, 2);
        tbl[11] = mk(1, 9, 4, 0, 0, 1, 0,  0, 3, 0, 0, 0, 0, 0, 2);

        reset = 1'b1;
        cmd_valid = 0; cmd_prn = 0; cmd_epochs = 0; cmd_sync = 0;
        sync_in = 0; abort = 0; gen_epoch = 0;
        idle(2);
        chk_out("reset", 1, 0, 0, 0, 0, 0, 0);
        chk("reset.cmd_ready", 32'(cmd_ready), 1);
        reset = 1'b0;
        $display("txn reset released");

        // T1, T4 and abort-in-IDLE as a vector table.
        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].v, tbl[i].prn, tbl[i].ep, tbl[i].sy, tbl[i].si, tbl[i].ab, tbl[i].ge, r);
            chk($sformatf("vec%0d.cmd_ready", i), 32'(r), 32'(tbl[i].rdy));
            chk_out($sformatf("vec%0d", i), tbl[i].xprn, tbl[i].xld, tbl[i].xena,
                    tbl[i].xbusy, tbl[i].xdone, tbl[i].xerr, tbl[i].xcnt);
            $display("txn vec %0d prn=%0d ld=%0d ena=%0d busy=%0d done=%0d err=%0d cnt=%0d",
                     i, gen_prn, gen_load, gen_ena, busy, done, cmd_err, epoch_count);
        end

        // T2: sync run; sync_in during LOAD ignored, ARM holds 20 cycles.
        step(1, 5, 0, 1, 0, 0, 0, r);
        chk_out("t2_load0", 5, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, r);
        chk_out("t2_load1", 5, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, r);
        chk_out("t2_arm", 5, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0, 0, (i % 5) == 0, r);
            chk($sformatf("t2_arm%0d.gen_ena", i), 32'(gen_ena), 0);
            chk($sformatf("t2_arm%0d.epoch_count", i), 32'(epoch_count), 0);
        end
        step(0, 0, 0, 0, 1, 0, 0, r);
        chk_out("t2_run", 5, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, r);
            chk($sformatf("t2_ep%0d.epoch_count", i), 32'(epoch_count), 32'(i + 1));
            chk($sformatf("t2_ep%0d.gen_ena", i), 32'(gen_ena), 1);
            idle(1);
        end
        $display("txn t2 run prn=%0d cnt=%0d", gen_prn, epoch_count);

        // T3: pending PRN change lands on the next epoch.
        step(1, 7, 1, 0, 0, 0, 0, r);
        chk("t3_acc.cmd_ready", 32'(r), 1);
        chk_out("t3_acc", 5, 0, 1, 1, 0, 0, 10);
        step(0, 0, 0, 0, 0, 0, 0, r);
        chk("t3_pend.cmd_ready", 32'(r), 0);
        step(1, 9, 3, 0, 0, 0, 0, r);
        chk("t3_blocked.cmd_ready", 32'(r), 0);
        step(0, 0, 0, 0, 0, 0, 1, r);
        chk_out("t3_swap", 7, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, r);
        chk("t3_load.cmd_ready", 32'(r), 1);
        step(0, 0, 0, 0, 0, 0, 0, r);
        chk_out("t3_run", 7, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, r);
        chk_out("t3_done", 7, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, r);
        chk_out("t3_idle", 7, 0, 0, 0, 0, 0, 1);
        $display("txn t3 prn=%0d cnt=%0d", gen_prn, epoch_count);

        // T5: abort in RUN with a full shadow.
        step(1, 9, 0, 0, 0, 0, 0, r);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 1, r);
        chk_out("t5_run", 9, 0, 1, 1, 0, 0, 1);
        step(1, 11, 4, 0, 0, 0, 0, r);
        chk("t5_acc.cmd_ready", 32'(r), 1);
        step(0, 0, 0, 0, 0, 1, 0, r);
        chk("t5_abort.cmd_ready", 32'(r), 0);
        chk_out("t5_abort", 9, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, r);
        chk("t5_after.cmd_ready", 32'(r), 1);
        chk_out("t5_after", 9, 0, 0, 0, 0, 0, 1);
        $display("txn t5 abort busy=%0d ena=%0d", busy, gen_ena);

        // T6: epoch and accept together, then reset during LOAD.
        step(1, 2, 0, 0, 0, 0, 0, r);
        idle(2);
        step(1, 4, 3, 0, 0, 0, 1, r);
        chk("t6_acc.cmd_ready", 32'(r), 1);
        chk_out("t6_coinc", 2, 0, 1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, r);
        chk("t6_pend.cmd_ready", 32'(r), 0);
        step(0, 0, 0, 0, 0, 0, 1, r);
        chk_out("t6_swap", 4, 1, 0, 1, 0, 0, 0);
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, r);
        reset = 1'b0;
        chk_out("t6_reset", 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, r);
        chk("t6_post.cmd_ready", 32'(r), 1);
        chk_out("t6_post", 1, 0, 0, 0, 0, 0, 0);
        $display("txn t6 reset prn=%0d busy=%0d", gen_prn, busy);

        // Finite run with full shadow ends at its target, not early, and chains.
        step(1, 6, 2, 0, 0, 0, 0, r);
        idle(2);
        step(1, 8, 0, 0, 0, 0, 0, r);
        step(0, 0, 0, 0, 0, 0, 1, r);
        chk_out("t7_ep1", 6, 0, 1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, r);
        chk_out("t7_chain", 8, 1, 0, 1, 0, 0, 0);
        idle(2);
        chk_out("t7_run", 8, 0, 1, 1, 0, 0, 0);
        $display("txn t7 chained prn=%0d", gen_prn);
        step(0, 0, 0, 0, 0, 1, 0, r);

        // Target reached on the same cycle a command is accepted: run ends
        // with done, the new command stays pending and loads from IDLE.
        step(1, 10, 1, 0, 0, 0, 0, r);
        idle(2);
        step(1, 12, 0, 0, 0, 0, 1, r);
        chk_out("t8_done", 10, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, r);
        chk_out("t8_pending", 12, 1, 0, 1, 0, 0, 0);
        $display("txn t8 pending prn=%0d", gen_prn);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
